// File: rtl/window_3x3_gen.sv
// Turns a raster-order pixel stream into fully-interior 3x3 windows.
// Two line buffers supply the upper rows. A 3x3 shift array forms the window.
module window_3x3_gen #(
    parameter int unsigned DATA_W = 17,
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_pix,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] p4,
    output logic [DATA_W-1:0] p5,
    output logic [DATA_W-1:0] p6,
    output logic [DATA_W-1:0] p7,
    output logic [DATA_W-1:0] p8,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;
    logic [COL_W-1:0]  nxt_col;
    logic [ROW_W-1:0]  nxt_row;
    logic              accept;
    logic              gen_win;
    logic              at_last;

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] win [9];

    // One output register stage: a new pixel is taken whenever that stage can move.
    assign in_ready = out_ready || !out_valid;
    assign accept   = in_valid && in_ready;

    // Position of the beat being accepted; in_sof forces it to (0,0).
    always_comb begin
        cur_col = in_sof ? '0 : col;
        cur_row = in_sof ? '0 : row;
        nxt_col = cur_col + COL_W'(1);
        nxt_row = cur_row;
        if (cur_col == COL_W'(IMG_W - 1)) begin
            nxt_col = '0;
            nxt_row = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + ROW_W'(1);
        end
        gen_win = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
        at_last = (cur_col == COL_W'(IMG_W - 1)) && (cur_row == ROW_W'(IMG_H - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            col <= nxt_col;
            row <= nxt_row;
        end
    end

    // Line buffers are rewritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[cur_col] <= lb1[cur_col];
            lb1[cur_col] <= in_pix;
        end
    end

    // Each window row shifts left; the new right column is lb0 / lb1 / in_pix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else if (accept) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb0[cur_col];
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb1[cur_col];
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= in_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= gen_win;
            out_last  <= gen_win && at_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    assign p0 = win[0];
    assign p1 = win[1];
    assign p2 = win[2];
    assign p3 = win[3];
    assign p4 = win[4];
    assign p5 = win[5];
    assign p6 = win[6];
    assign p7 = win[7];
    assign p8 = win[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on a 4x4 image.
// Checks every cycle against an image-array model, plus literal window expectations.
module tb_window_3x3_gen;

    localparam int unsigned DATA_W = 17;
    localparam int unsigned IMG_W  = 4;
    localparam int unsigned IMG_H  = 4;

    typedef struct packed {
        logic [8:0][DATA_W-1:0] p;
        logic                   last;
    } win_t;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] in_pix;
    logic              in_valid;
    logic              in_sof;
    logic              in_ready;
    logic [DATA_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    window_3x3_gen #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_pix(in_pix), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    win_t got_q[$];
    int   stall_left = 0;
    bit   rnd_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic win_t dut_win();
        win_t w;
        w.p[0] = p0; w.p[1] = p1; w.p[2] = p2;
        w.p[3] = p3; w.p[4] = p4; w.p[5] = p5;
        w.p[6] = p6; w.p[7] = p7; w.p[8] = p8;
        w.last = out_last;
        return w;
    endfunction

    // Reference: the accepted image plus the window each accepted pixel must produce.
    logic [DATA_W-1:0] img [IMG_H][IMG_W];
    int   mr, mc, pr, pc;
    bit   exp_valid, exp_last, prev_stall, acc;
    win_t exp_w, prev_w, dw;

    always @(negedge clk) begin
        if (!rst_n) begin
            mr = 0; mc = 0; exp_valid = 0; exp_last = 0; prev_stall = 0;
        end else begin
            dw = dut_win();
            check("in_ready", in_ready, out_ready || !out_valid);
            check("out_valid", out_valid, exp_valid);
            if (exp_valid && out_valid) begin
                for (int i = 0; i < 9; i++)
                    check($sformatf("p%0d", i), dw.p[i], exp_w.p[i]);
                check("out_last", dw.last, exp_last);
            end
            if (prev_stall)
                check("hold_stable", dw === prev_w, 1);
            prev_stall = out_valid && !out_ready;
            prev_w = dw;
            if (out_valid && out_ready)
                got_q.push_back(dw);
            acc = in_valid && in_ready;
            if (acc) begin
                pr = in_sof ? 0 : mr;
                pc = in_sof ? 0 : mc;
                img[pr][pc] = in_pix;
                exp_valid = (pr >= 2) && (pc >= 2);
                if (exp_valid) begin
                    for (int i = 0; i < 9; i++)
                        exp_w.p[i] = img[pr - 2 + i / 3][pc - 2 + i % 3];
                    exp_last = (pr == IMG_H - 1) && (pc == IMG_W - 1);
                end
                pc++;
                if (pc == IMG_W) begin
                    pc = 0;
                    pr = (pr == IMG_H - 1) ? 0 : pr + 1;
                end
                mr = pr; mc = pc;
            end else if (out_ready) begin
                exp_valid = 0;
            end
        end
    end

    // Downstream: random ready, or a scripted stall on the first window seen.
    always @(posedge clk) begin
        #1;
        if (rnd_mode)
            out_ready = 1'($urandom_range(0, 1));
        else if (stall_left > 0 && out_valid) begin
            out_ready = 1'b0;
            stall_left--;
        end else
            out_ready = 1'b1;
    end

    task automatic send_pix(input logic [DATA_W-1:0] pix, input bit sof, input bit bub);
        bit done = 0;
        if (bub) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_pix = pix; in_sof = sof;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_sof = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL accept_timeout: actual=0 required=1");
        end
    endtask

    // bub: 0 none, 1 alternate, 2 random.
    task automatic send_frame(input int base, input int bub, input bit rnd_pix);
        logic [DATA_W-1:0] v;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                v = rnd_pix ? DATA_W'($urandom) : DATA_W'(base + 16 * r + c);
                send_pix(v, (r == 0) && (c == 0),
                         (bub == 1) || ((bub == 2) && ($urandom_range(0, 2) == 0)));
            end
    endtask

    task automatic drain();
        bit idle = 0;
        in_valid = 1'b0;
        for (int k = 0; k < 100 && !idle; k++) begin
            @(posedge clk); #1;
            idle = !out_valid;
        end
        if (!idle) begin
            total++; bad++;
            $display("FAIL drain_timeout: actual=1 required=0");
        end
    endtask

    task automatic check_first(input string tag, input int idx);
        int ref1 [9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
        win_t w;
        if (idx >= got_q.size()) begin
            total++; bad++;
            $display("FAIL %s_missing: actual=%0d required=%0d", tag, got_q.size(), idx + 1);
        end else begin
            w = got_q[idx];
            for (int i = 0; i < 9; i++)
                check($sformatf("%s_p%0d", tag, i), w.p[i], ref1[i]);
            check({tag, "_last"}, w.last, 0);
        end
    endtask

    int   s0;
    win_t w;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_pix = '0; in_sof = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_p0", p0, 0);
        check("rst_p8", p8, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic window
        s0 = got_q.size();
        send_frame(0, 0, 0);
        drain();
        check("s1_count", got_q.size() - s0, 4);
        check_first("s1_first", s0);
        if (got_q.size() >= s0 + 4) begin
            w = got_q[s0 + 3];
            check("s1_last_p0", w.p[0], 17);
            check("s1_last_p8", w.p[8], 51);
            check("s1_last_flag", w.last, 1);
            w = got_q[s0 + 2];
            check("s1_third_flag", w.last, 0);
        end

        // Backpressure
        stall_left = 3;
        s0 = got_q.size();
        send_frame(0, 0, 0);
        drain();
        check("s2_stalls_used", stall_left, 0);
        check("s2_count", got_q.size() - s0, 4);
        check_first("s2_first", s0);

        // Input bubbles
        s0 = got_q.size();
        send_frame(0, 1, 0);
        drain();
        check("s3_count", got_q.size() - s0, 4);
        check_first("s3_first", s0);

        // Back-to-back frames
        s0 = got_q.size();
        send_frame(0, 0, 0);
        send_frame(100, 0, 0);
        drain();
        check("s4_count", got_q.size() - s0, 8);
        if (got_q.size() >= s0 + 8) begin
            w = got_q[s0 + 4];
            check("s4_f2_p0", w.p[0], 100);
            check("s4_f2_p8", w.p[8], 134);
            w = got_q[s0 + 3];
            check("s4_f1_last", w.last, 1);
        end

        // in_sof resync at pixel (1,2) of a partial frame
        s0 = got_q.size();
        for (int i = 0; i < 6; i++)
            send_pix(DATA_W'(200 + i), i == 0, 0);
        send_frame(0, 0, 0);
        drain();
        check("s5_count", got_q.size() - s0, 4);
        check_first("s5_first", s0);

        // Async reset mid-frame with a window pending
        for (int i = 0; i < 11; i++)
            send_pix(DATA_W'(16 * (i / 4) + i % 4), i == 0, 0);
        check("s6_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_rst_valid", out_valid, 0);
        check("s6_rst_last", out_last, 0);
        check("s6_rst_p0", p0, 0);
        check("s6_rst_p4", p4, 0);
        check("s6_rst_p8", p8, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        s0 = got_q.size();
        send_frame(0, 0, 0);
        drain();
        check("s6_count", got_q.size() - s0, 4);
        check_first("s6_first", s0);

        // Randomized pixels, bubbles and backpressure
        rnd_mode = 1;
        s0 = got_q.size();
        for (int f = 0; f < 3; f++)
            send_frame(0, 2, 1);
        drain();
        rnd_mode = 0;
        check("rnd_count", got_q.size() - s0, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=1 required=0");
        $fatal(1, "timeout");
    end

endmodule
